rgb_stream_mapper: RTL and testbench

- Parametrised successor to the fixed-geometry RGB front end.
- Consumes the 24-bit pixel stream popped from the video input FIFO, framed by hsync/vsync.
- Emits each pixel with its µblock coordinates, one cycle after input, with per-frame colour-order selection.
- Adds slice/frame accounting and malformed-frame detection; feeds the framebuffer write side.

---
 rtl/rgb_stream_pkg.sv | 51 +++++
 rtl/rgb_coord_counter.sv | 86 ++++++++
 rtl/rgb_stream_mapper.sv | 159 +++++++++++++++
 tb/tb_rgb_stream_mapper.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_stream_pkg.sv
// Shared types, default geometry and the channel reorder helper for the
// RGB stream mapper and its coordinate counter.
package rgb_stream_pkg;

  typedef enum logic [1:0] {
    ORDER_PASS = 2'd0,
    ORDER_REV  = 2'd1,
    ORDER_ROT  = 2'd2,
    ORDER_RSVD = 2'd3
  } color_order_e;

  localparam int unsigned DEF_PIX_W    = 8;
  localparam int unsigned DEF_PIX_H    = 16;
  localparam int unsigned DEF_BLK_COLS = 5;
  localparam int unsigned DEF_BLK_ROWS = 3;
  localparam int unsigned DEF_N_SLICES = 128;
  localparam int unsigned DEF_DW       = 24;

  // Widest pixel the reorder helper handles; callers narrow the result back to DW.
  localparam int unsigned MAX_DW = 96;

  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Output channel k (c0 = LSBs) takes input channel src. REV yields {c0,c1,c2};
  // ROT rotates the channels left by one, yielding {c1,c0,c2}.
  function automatic logic [MAX_DW-1:0] reorder(input logic [MAX_DW-1:0] pix,
                                                input color_order_e     order,
                                                input int unsigned      cw);
    logic [MAX_DW-1:0] res;
    int unsigned       k;
    int unsigned       src;
    int unsigned       idx;
    res = '0;
    for (int unsigned b = 0; b < MAX_DW; b++) begin
      if (b < 3 * cw) begin
        k = b / cw;
        case (order)
          ORDER_REV: src = 2 - k;
          ORDER_ROT: src = (k + 2) % 3;
          default:   src = k;
        endcase
        idx    = src * cw + (b - k * cw);
        res[b] = pix[idx];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_coord_counter.sv
// Nested wrap counter giving a pixel's position: column, block column, line,
// block row and slice; the slice stage saturates at N_SLICES to flag overflow.
module rgb_coord_counter
  import rgb_stream_pkg::*;
#(
  parameter  int unsigned PIX_W    = DEF_PIX_W,
  parameter  int unsigned PIX_H    = DEF_PIX_H,
  parameter  int unsigned BLK_COLS = DEF_BLK_COLS,
  parameter  int unsigned BLK_ROWS = DEF_BLK_ROWS,
  parameter  int unsigned N_SLICES = DEF_N_SLICES,
  localparam int unsigned CW       = clog2w(PIX_W),
  localparam int unsigned LW       = clog2w(PIX_H),
  localparam int unsigned BCW      = clog2w(BLK_COLS),
  localparam int unsigned BLW      = clog2w(BLK_ROWS),
  localparam int unsigned SW       = clog2w(N_SLICES + 1)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           clr_i,
  input  logic           inc_i,
  output logic [CW-1:0]  col_o,
  output logic [BCW-1:0] bcol_o,
  output logic [LW-1:0]  line_o,
  output logic [BLW-1:0] bline_o,
  output logic [SW-1:0]  slice_o,
  output logic [3:0]     max_o,
  output logic           ovf_o
);

  logic [CW-1:0]  col_q, col_d, colCur;
  logic [BCW-1:0] bcol_q, bcol_d, bcolCur;
  logic [LW-1:0]  line_q, line_d, lineCur;
  logic [BLW-1:0] bline_q, bline_d, blineCur;
  logic [SW-1:0]  slice_q, slice_d, sliceCur;
  logic [3:0]     carry;

  // A clear restarts from zero in the same cycle, so a pixel arriving with the
  // clear is position zero and the increment then moves past it.
  always_comb begin
    colCur   = clr_i ? '0 : col_q;
    bcolCur  = clr_i ? '0 : bcol_q;
    lineCur  = clr_i ? '0 : line_q;
    blineCur = clr_i ? '0 : bline_q;
    sliceCur = clr_i ? '0 : slice_q;

    max_o[0] = (colCur   == CW'(PIX_W - 1));
    max_o[1] = (bcolCur  == BCW'(BLK_COLS - 1));
    max_o[2] = (lineCur  == LW'(PIX_H - 1));
    max_o[3] = (blineCur == BLW'(BLK_ROWS - 1));
    ovf_o    = (sliceCur == SW'(N_SLICES));

    carry[0] = inc_i    & max_o[0];
    carry[1] = carry[0] & max_o[1];
    carry[2] = carry[1] & max_o[2];
    carry[3] = carry[2] & max_o[3];

    col_d   = inc_i    ? (max_o[0] ? '0 : colCur + 1'b1)   : colCur;
    bcol_d  = carry[0] ? (max_o[1] ? '0 : bcolCur + 1'b1)  : bcolCur;
    line_d  = carry[1] ? (max_o[2] ? '0 : lineCur + 1'b1)  : lineCur;
    bline_d = carry[2] ? (max_o[3] ? '0 : blineCur + 1'b1) : blineCur;
    slice_d = (carry[3] && !ovf_o) ? sliceCur + 1'b1 : sliceCur;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col_q   <= '0;
      bcol_q  <= '0;
      line_q  <= '0;
      bline_q <= '0;
      slice_q <= '0;
    end else begin
      col_q   <= col_d;
      bcol_q  <= bcol_d;
      line_q  <= line_d;
      bline_q <= bline_d;
      slice_q <= slice_d;
    end
  end

  assign col_o   = colCur;
  assign bcol_o  = bcolCur;
  assign line_o  = lineCur;
  assign bline_o = blineCur;
  assign slice_o = sliceCur;

endmodule

// File: rtl/rgb_stream_mapper.sv
// Maps the FIFO pixel stream onto µblock coordinates with per-frame colour
// order, slice accounting and malformed-frame detection for the framebuffer.
module rgb_stream_mapper
  import rgb_stream_pkg::*;
#(
  parameter  int unsigned PIX_W    = DEF_PIX_W,
  parameter  int unsigned PIX_H    = DEF_PIX_H,
  parameter  int unsigned BLK_COLS = DEF_BLK_COLS,
  parameter  int unsigned BLK_ROWS = DEF_BLK_ROWS,
  parameter  int unsigned N_SLICES = DEF_N_SLICES,
  parameter  int unsigned DW       = DEF_DW,
  localparam int unsigned CW       = clog2w(PIX_W),
  localparam int unsigned LW       = clog2w(PIX_H),
  localparam int unsigned BCW      = clog2w(BLK_COLS),
  localparam int unsigned BLW      = clog2w(BLK_ROWS),
  localparam int unsigned SW       = clog2w(N_SLICES),
  localparam int unsigned FSW      = clog2w(N_SLICES + 1)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [DW-1:0]  rgb,
  input  logic           hsync,
  input  logic           vsync,
  input  logic           empty,
  input  logic           rgb_enable,
  input  logic [1:0]     color_order,
  output logic [DW-1:0]  pixel_data,
  output logic           pixel_valid,
  output logic [CW-1:0]  pixel_col,
  output logic [LW-1:0]  pixel_line,
  output logic [BCW-1:0] block_col,
  output logic [BLW-1:0] block_line,
  output logic [SW-1:0]  wslice_cnt,
  output logic           EOS,
  output logic           EOF,
  output logic           frame_err,
  output logic [FSW-1:0] frame_slices
);

  logic           adv, frameStart, frameEnd, active;
  logic           enableEff, ovf, inSliceZero;
  color_order_e   orderEff;

  logic [CW-1:0]  colCur;
  logic [BCW-1:0] bcolCur;
  logic [LW-1:0]  lineCur;
  logic [BLW-1:0] blineCur;
  logic [FSW-1:0] sliceCur;
  logic [3:0]     maxFlags;

  logic           vsync_q, enable_q;
  color_order_e   order_q;
  logic [DW-1:0]  pixelData_q;
  logic           pixelValid_q, eos_q, eof_q, frameErr_q;
  logic [CW-1:0]  pixelCol_q;
  logic [LW-1:0]  pixelLine_q;
  logic [BCW-1:0] blockCol_q;
  logic [BLW-1:0] blockLine_q;
  logic [SW-1:0]  wslice_q;
  logic [FSW-1:0] frameSlices_q;

  assign adv         = !empty;
  assign frameStart  = adv & vsync & !vsync_q;
  assign frameEnd    = adv & !vsync & vsync_q;
  assign active      = adv & vsync & hsync;
  assign enableEff   = frameStart ? rgb_enable : enable_q;
  assign orderEff    = frameStart ? color_order_e'(color_order) : order_q;
  assign inSliceZero = (colCur == '0) && (bcolCur == '0) &&
                       (lineCur == '0) && (blineCur == '0);

  rgb_coord_counter #(
    .PIX_W   (PIX_W),
    .PIX_H   (PIX_H),
    .BLK_COLS(BLK_COLS),
    .BLK_ROWS(BLK_ROWS),
    .N_SLICES(N_SLICES)
  ) u_coord (
    .clk    (clk),
    .nrst   (nrst),
    .clr_i  (frameStart),
    .inc_i  (active & !ovf),
    .col_o  (colCur),
    .bcol_o (bcolCur),
    .line_o (lineCur),
    .bline_o(blineCur),
    .slice_o(sliceCur),
    .max_o  (maxFlags),
    .ovf_o  (ovf)
  );

  // Pulses and valid are recomputed every clock; data and coordinates only move
  // with an active pixel, and frame state only moves when the FIFO advances.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vsync_q       <= 1'b0;
      enable_q      <= 1'b0;
      order_q       <= ORDER_PASS;
      pixelData_q   <= '0;
      pixelValid_q  <= 1'b0;
      pixelCol_q    <= '0;
      pixelLine_q   <= '0;
      blockCol_q    <= '0;
      blockLine_q   <= '0;
      wslice_q      <= '0;
      eos_q         <= 1'b0;
      eof_q         <= 1'b0;
      frameErr_q    <= 1'b0;
      frameSlices_q <= '0;
    end else begin
      pixelValid_q <= active & enableEff & !ovf;
      eos_q        <= active & (&maxFlags) & !ovf;
      eof_q        <= frameEnd;

      if (adv) begin
        vsync_q <= vsync;
      end

      if (frameStart) begin
        enable_q <= rgb_enable;
        order_q  <= orderEff;
      end

      if (active) begin
        pixelData_q <= DW'(reorder(MAX_DW'(rgb), orderEff, DW / 3));
        pixelCol_q  <= colCur;
        pixelLine_q <= lineCur;
        blockCol_q  <= bcolCur;
        blockLine_q <= blineCur;
        wslice_q    <= SW'(sliceCur);
      end

      // A frame is clean only if it closes exactly on a slice boundary after N_SLICES slices.
      if (frameStart) begin
        frameErr_q <= 1'b0;
      end else if (active && ovf) begin
        frameErr_q <= 1'b1;
      end else if (frameEnd && (!inSliceZero || (sliceCur != FSW'(N_SLICES)))) begin
        frameErr_q <= 1'b1;
      end

      if (frameEnd) begin
        frameSlices_q <= sliceCur;
      end
    end
  end

  assign pixel_data   = pixelData_q;
  assign pixel_valid  = pixelValid_q;
  assign pixel_col    = pixelCol_q;
  assign pixel_line   = pixelLine_q;
  assign block_col    = blockCol_q;
  assign block_line   = blockLine_q;
  assign wslice_cnt   = wslice_q;
  assign EOS          = eos_q;
  assign EOF          = eof_q;
  assign frame_err    = frameErr_q;
  assign frame_slices = frameSlices_q;

endmodule

// File: tb/tb_rgb_stream_mapper.sv
// Scoreboard bench for rgb_stream_mapper on a reduced geometry: the driver
// queues expected outputs, a negedge monitor pops and compares them.
module tb_rgb_stream_mapper;

  localparam int PW = 4;
  localparam int PH = 2;
  localparam int BC = 3;
  localparam int BR = 2;
  localparam int NS = 4;
  localparam int SP = PW * BC * PH * BR;

  logic        clk = 1'b0;
  logic        nrst;
  logic [23:0] rgb;
  logic        hsync, vsync, empty, rgb_enable;
  logic [1:0]  color_order;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [1:0]  pixel_col;
  logic [0:0]  pixel_line;
  logic [1:0]  block_col;
  logic [0:0]  block_line;
  logic [1:0]  wslice_cnt;
  logic        EOS, EOF, frame_err;
  logic [2:0]  frame_slices;

  typedef struct {
    logic [23:0] data;
    int          col, bcol, line, bline, slice;
    bit          eos, valid;
    longint      stamp;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  longint eofStamp = -1;
  int     expSlices = 0;
  bit     expErr = 1'b0;
  bit     vsPrevM = 1'b0;
  bit     enM = 1'b0;
  logic [1:0] ordM = 2'd0;
  int     nM = 0;

  rgb_stream_mapper #(
    .PIX_W(PW), .PIX_H(PH), .BLK_COLS(BC), .BLK_ROWS(BR), .N_SLICES(NS), .DW(24)
  ) dut (
    .clk(clk), .nrst(nrst), .rgb(rgb), .hsync(hsync), .vsync(vsync), .empty(empty),
    .rgb_enable(rgb_enable), .color_order(color_order), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_col(pixel_col), .pixel_line(pixel_line),
    .block_col(block_col), .block_line(block_line), .wslice_cnt(wslice_cnt),
    .EOS(EOS), .EOF(EOF), .frame_err(frame_err), .frame_slices(frame_slices)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] refReorder(input logic [23:0] p, input logic [1:0] ord);
    logic [7:0] c0, c1, c2;
    c0 = p[7:0];
    c1 = p[15:8];
    c2 = p[23:16];
    case (ord)
      2'd1:    return {c0, c1, c2};
      2'd2:    return {c1, c0, c2};
      default: return p;
    endcase
  endfunction

  function automatic logic [23:0] handExp(input logic [1:0] ord);
    case (ord)
      2'd1:    return 24'h332211;
      2'd2:    return 24'h223311;
      default: return 24'h112233;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one input cycle and update the reference frame model.
  task automatic applyStimulus(input bit vs, input bit hs, input bit emp, input logic [23:0] pix,
                               input bit en, input logic [1:0] ord,
                               input bit useExp, input logic [23:0] expData);
    exp_t e;
    int   sl, r;
    @(negedge clk);
    vsync = vs; hsync = hs; empty = emp; rgb = pix; rgb_enable = en; color_order = ord;
    if (!emp) begin
      if (vs && !vsPrevM) begin
        enM = en; ordM = ord; nM = 0;
      end
      if (vs && hs) begin
        sl = nM / SP;
        r  = nM % SP;
        if (sl < NS && (enM || r == SP - 1)) begin
          e.data  = useExp ? expData : refReorder(pix, ordM);
          e.col   = r % PW;
          e.bcol  = (r / PW) % BC;
          e.line  = (r / (PW * BC)) % PH;
          e.bline = r / (PW * BC * PH);
          e.slice = sl;
          e.eos   = (r == SP - 1);
          e.valid = enM;
          e.stamp = cyc + 1;
          sb.push_back(e);
        end
        nM++;
      end
      if (!vs && vsPrevM) begin
        eofStamp  = cyc + 1;
        expSlices = (nM / SP < NS) ? nM / SP : NS;
        expErr    = (nM != NS * SP);
      end
      vsPrevM = vs;
    end
  endtask

  task automatic sendFrame(input int nPix, input bit en, input logic [1:0] ord,
                           input bit stall, input bit leadBlank, input bit checkClear);
    bit          enNow;
    logic [1:0]  ordNow;
    logic [23:0] pix;
    for (int i = 0; i < nPix; i++) begin
      enNow  = (i >= nPix / 2) ? !en : en;
      ordNow = (i >= nPix / 2) ? (ord ^ 2'd1) : ord;
      if (i == 0 && leadBlank) applyStimulus(1, 0, 0, 24'h0, en, ord, 0, 24'h0);
      if (i > 0 && i % 37 == 0) applyStimulus(1, 0, 0, 24'h0, enNow, ordNow, 0, 24'h0);
      if (stall) applyStimulus(0, 1, 1, 24'hDEADBE, !enNow, ~ordNow, 0, 24'h0);
      pix = (i == 0) ? 24'h112233 : {8'(i * 5 + 1), 8'(i * 11 + 7), 8'(i * 3 + 200)};
      applyStimulus(1, 1, 0, pix, enNow, ordNow, i == 0, handExp(ord));
      if (checkClear && i == 2) checkOutput("err_cleared", frame_err, 0);
    end
    if (stall) applyStimulus(0, 1, 1, 24'hDEADBE, en, ord, 0, 24'h0);
    applyStimulus(0, 0, 0, 24'h0, en, ord, 0, 24'h0);
    repeat (2) applyStimulus(0, 0, 1, 24'h0, en, ord, 0, 24'h0);
  endtask

  // Monitor: every presented output must match the head of the scoreboard at its stamp.
  always @(negedge clk) begin
    exp_t e;
    if (nrst === 1'b1) begin
      while (sb.size() > 0 && sb[0].stamp < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missing_out: no output at cycle %0d expected slice %0d col %0d",
                 sb[0].stamp, sb[0].slice, sb[0].col);
        void'(sb.pop_front());
      end
      if (pixel_valid || EOS) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_out: valid=%0b eos=%0b at cycle %0d expected none",
                   pixel_valid, EOS, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("out_cycle", 64'(cyc), 64'(e.stamp));
          checkOutput("out_fields",
            {pixel_valid, EOS, pixel_data, 4'(pixel_col), 4'(block_col), 4'(pixel_line),
             4'(block_line), 4'(wslice_cnt)},
            {e.valid, e.eos, e.data, 4'(e.col), 4'(e.bcol), 4'(e.line), 4'(e.bline), 4'(e.slice)});
        end
      end
      if (EOF || cyc == eofStamp) begin
        checkOutput("eof_pulse", EOF, cyc == eofStamp);
        checkOutput("frame_slices", frame_slices, expSlices);
        checkOutput("frame_err", frame_err, expErr);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vsync = 0; hsync = 0; empty = 1; rgb = '0; rgb_enable = 0; color_order = 0;
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #12;
    checkOutput("rst_valid", pixel_valid, 0);
    checkOutput("rst_pulses", {EOS, EOF, frame_err}, 0);
    checkOutput("rst_data", pixel_data, 0);
    checkOutput("rst_counts", {wslice_cnt, frame_slices, pixel_col, block_col}, 0);
    @(negedge clk);
    nrst = 1'b1;

    $display("[TB] frame A: enable=1 order=1 clean");
    sendFrame(NS * SP, 1, 2'd1, 0, 0, 0);
    $display("[TB] frame B: enable=0 at start");
    sendFrame(NS * SP, 0, 2'd0, 0, 1, 0);
    $display("[TB] frame C: empty every other cycle");
    sendFrame(NS * SP, 1, 2'd3, 1, 0, 0);
    $display("[TB] frame D: truncated in slice 2");
    sendFrame(2 * SP + 20, 1, 2'd0, 0, 1, 0);
    $display("[TB] frame E: one slice too many");
    sendFrame((NS + 1) * SP, 1, 2'd2, 0, 0, 1);

    $display("[TB] reset mid-slice");
    for (int i = 0; i < 30; i++)
      applyStimulus(1, 1, 0, 24'h0A0B0C + 24'(i), 1, 2'd0, 0, 24'h0);
    @(posedge clk);
    #2;
    checkOutput("pre_rst_valid", pixel_valid, 1);
    nrst = 1'b0;
    #1;
    checkOutput("async_rst_valid", pixel_valid, 0);
    checkOutput("async_rst_outs",
      {pixel_data, EOS, EOF, frame_err, frame_slices, pixel_col, block_col, wslice_cnt}, 0);
    vsync = 0; hsync = 1; empty = 1;
    sb.delete();
    eofStamp = -1;
    vsPrevM = 0; enM = 0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 6; i++)
      applyStimulus(0, 1, 0, 24'h445566, 1, 2'd2, 0, 24'h0);
    $display("[TB] frame G: order=2 after reset");
    sendFrame(8, 1, 2'd2, 0, 0, 0);

    repeat (4) @(negedge clk);
    checkOutput("queue_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
